// File: rtl/mux21_pkg.sv
// Shared types for the two-class egress merger: FSM states and counter widths.
package mux21_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int BURST_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1
  } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Weighted round-robin pop arbiter for two class FIFOs; pop strobes are registered.
// Up to BURST pops from one class while the other waits; almost_full freezes state and counter.
module arb_rr2
  import mux21_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fifo_empty_0,
  input  logic fifo_empty_1,
  input  logic almost_full,
  output logic pop_0,
  output logic pop_1
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);
  localparam logic [BURST_W-1:0] CNT_ONE   = BURST_W'(1);

  state_t             state, state_n;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_n;
  logic               last, last_n;
  logic               pop_0_n, pop_1_n;
  logic               cur_cls, cur_empty, oth_empty;

  always_comb begin
    state_n     = state;
    burst_cnt_n = burst_cnt;
    last_n      = last;
    pop_0_n     = 1'b0;
    pop_1_n     = 1'b0;
    cur_cls     = (state == SERVE1);
    cur_empty   = cur_cls ? fifo_empty_1 : fifo_empty_0;
    oth_empty   = cur_cls ? fifo_empty_0 : fifo_empty_1;

    case (state)
      IDLE: begin
        if (!almost_full && !(fifo_empty_0 && fifo_empty_1)) begin
          burst_cnt_n = CNT_ONE;
          // last==1 means class 1 was served most recently, so class 0 wins a tie
          if (!fifo_empty_0 && (fifo_empty_1 || last)) begin
            state_n = SERVE0;
            pop_0_n = 1'b1;
          end else begin
            state_n = SERVE1;
            pop_1_n = 1'b1;
          end
        end
      end
      SERVE0, SERVE1: begin
        if (!almost_full) begin
          if (!cur_empty && (burst_cnt < BURST_MAX || oth_empty)) begin
            pop_0_n = !cur_cls;
            pop_1_n = cur_cls;
            if (burst_cnt < BURST_MAX) burst_cnt_n = burst_cnt + CNT_ONE;
          end else if (!oth_empty) begin
            state_n     = cur_cls ? SERVE0 : SERVE1;
            pop_0_n     = cur_cls;
            pop_1_n     = !cur_cls;
            burst_cnt_n = CNT_ONE;
            last_n      = cur_cls;
          end else begin
            state_n = IDLE;
            last_n  = cur_cls;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= 1'b1;
      pop_0     <= 1'b0;
      pop_1     <= 1'b0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_cnt_n;
      last      <= last_n;
      pop_0     <= pop_0_n;
      pop_1     <= pop_1_n;
    end
  end

endmodule

// File: rtl/mux21_rr_pop.sv
// Merges two class FIFOs into one tagged stream; pop at cycle N appears on out at N+2.
// almost_full stops new pops; words already popped are still delivered.
module mux21_rr_pop
  import mux21_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic              almost_full,
  output logic              pop_0,
  output logic              pop_1,
  output logic [DATA_W-1:0] out,
  output logic              push_out,
  output logic              class_out
);

  logic rd_vld;
  logic rd_cls;

  arb_rr2 #(
    .BURST(BURST)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1),
    .almost_full (almost_full),
    .pop_0       (pop_0),
    .pop_1       (pop_1)
  );

  // rd_vld/rd_cls track the FIFO read-register stage so the right input is captured
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld    <= 1'b0;
      rd_cls    <= 1'b0;
      out       <= '0;
      push_out  <= 1'b0;
      class_out <= 1'b0;
    end else begin
      rd_vld   <= pop_0 | pop_1;
      rd_cls   <= pop_1;
      push_out <= rd_vld;
      if (rd_vld) begin
        out       <= rd_cls ? in1 : in0;
        class_out <= rd_cls;
      end
    end
  end

endmodule
